// File: rtl/aoi21_test_sequencer_if.sv
// AOI21 BIST bus: control/status between host and sequencer, plus CUT drive/observe.
// Latency: none (wires only).
// Backpressure: none; START/ABORT are level-sampled and DONE is a pulse.
//
// Signals:
//   START, ABORT      host -> sequencer run control
//   Y                 CUT -> sequencer, combinational output of the cell under test
//   A, B, C           sequencer -> CUT, registered stimulus
//   BUSY, DONE, PASS  sequencer -> host run status
//   ERR_CNT           saturating mismatch count
//   FAIL_VALID        a mismatch has been seen in this run
//   FAIL_VEC          first failing vector {A,B,C}
interface aoi21_test_sequencer_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 START;
  logic                 ABORT;
  logic                 Y;
  logic                 A;
  logic                 B;
  logic                 C;
  logic                 BUSY;
  logic                 DONE;
  logic                 PASS;
  logic [ERR_CNT_W-1:0] ERR_CNT;
  logic                 FAIL_VALID;
  logic [2:0]           FAIL_VEC;

  // Sequencer side.
  modport master (
    input  START, ABORT, Y,
    output A, B, C, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC
  );

  // Host / CUT side.
  modport slave (
    output START, ABORT, Y,
    input  A, B, C, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC
  );
endinterface

// File: rtl/aoi21_test_sequencer.sv
// AOI21 BIST sequencer: sweeps all 8 {A,B,C} vectors LOOPS times, checks Y against the golden function.
// Latency: each vector takes SETTLE_CYCLES+1 cycles; DONE pulses the cycle after the last sample.
// Backpressure: none; START is ignored while a run is in progress, ABORT ends a run at the next edge.
//
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous active-high reset
//   bus   aoi21_test_sequencer_if.master (run control, CUT drive/observe, result status)
module aoi21_test_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int LOOPS         = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  aoi21_test_sequencer_if.master        bus
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
        LOOPS < 1 || LOOPS > 255 || ERR_CNT_W < 1) begin : g_bad_params
      $error("aoi21_test_sequencer: SETTLE_CYCLES and LOOPS must be 1..255, ERR_CNT_W >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [7:0]           SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]           LOOP_LAST   = 8'(LOOPS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE     = ERR_CNT_W'(1);

  state_t               state_q, state_d;
  logic [7:0]           settle_q, settle_d;
  logic [2:0]           vec_q, vec_d;
  logic [7:0]           loop_q, loop_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 fail_vld_q, fail_vld_d;
  logic [2:0]           fail_vec_q, fail_vec_d;
  logic                 pass_q, pass_d;
  logic                 busy, done;
  logic                 exp_y;
  logic                 mismatch;

  // Golden AOI21 of the vector currently being driven (vec_q is the registered drive).
  assign exp_y    = ~((vec_q[2] & vec_q[1]) | vec_q[0]);
  assign mismatch = bus.Y ^ exp_y;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      vec_q      <= '0;
      loop_q     <= '0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      fail_vec_q <= 3'b000;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      vec_q      <= vec_d;
      loop_q     <= loop_d;
      err_q      <= err_d;
      fail_vld_q <= fail_vld_d;
      fail_vec_q <= fail_vec_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    vec_d      = vec_q;
    loop_d     = loop_q;
    err_d      = err_q;
    fail_vld_d = fail_vld_q;
    fail_vec_d = fail_vec_q;
    pass_d     = pass_q;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        // START beats a simultaneous ABORT here; ABORT alone is a no-op in IDLE.
        if (bus.START) begin
          state_d    = SETTLE;
          settle_d   = SETTLE_LOAD;
          vec_d      = 3'b000;
          loop_d     = '0;
          err_d      = '0;
          fail_vld_d = 1'b0;
          fail_vec_d = 3'b000;
          pass_d     = 1'b0;
        end
      end

      SETTLE: begin
        busy = 1'b1;
        if (bus.ABORT) begin
          state_d = IDLE;
          vec_d   = 3'b000;
          pass_d  = 1'b0;
        end else if (settle_q == 8'd0) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end

      SAMPLE: begin
        busy = 1'b1;
        if (bus.ABORT) begin
          // Abort discards this sample; results so far are kept for inspection.
          state_d = IDLE;
          vec_d   = 3'b000;
          pass_d  = 1'b0;
        end else begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_ONE;
            end
            if (!fail_vld_q) begin
              fail_vld_d = 1'b1;
              fail_vec_d = vec_q;
            end
          end
          if (vec_q != 3'b111) begin
            state_d  = SETTLE;
            vec_d    = vec_q + 3'd1;
            settle_d = SETTLE_LOAD;
          end else if (loop_q != LOOP_LAST) begin
            state_d  = SETTLE;
            vec_d    = 3'b000;
            loop_d   = loop_q + 8'd1;
            settle_d = SETTLE_LOAD;
          end else begin
            state_d = FINISH;
            vec_d   = 3'b000;
            // Account for this final sample so PASS is valid alongside DONE.
            pass_d  = (err_q == '0) && !mismatch;
          end
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        vec_d   = 3'b000;
      end
    endcase
  end

  assign bus.A          = vec_q[2];
  assign bus.B          = vec_q[1];
  assign bus.C          = vec_q[0];
  assign bus.BUSY       = busy;
  assign bus.DONE       = done;
  assign bus.PASS       = pass_q;
  assign bus.ERR_CNT    = err_q;
  assign bus.FAIL_VALID = fail_vld_q;
  assign bus.FAIL_VEC   = fail_vec_q;

endmodule

// File: tb/tb_aoi21_test_sequencer.sv
// Directed bench for aoi21_test_sequencer with golden and faulty CUT models.
// Latency: checks run-length and per-cycle vector drive against hand-computed values.
// Backpressure: n/a; three instances cover LOOPS=2 and a 2-bit saturating counter.
module tb_aoi21_test_sequencer;

  localparam int M_GOLD   = 0;
  localparam int M_SA0    = 1;
  localparam int M_SA1    = 2;
  localparam int M_BRIDGE = 3;

  logic CLK;
  logic RST;
  int   mode0, mode1, mode2;
  int   n_cmp;
  int   n_err;

  aoi21_test_sequencer_if #(.ERR_CNT_W(8)) if0 ();
  aoi21_test_sequencer_if #(.ERR_CNT_W(8)) if1 ();
  aoi21_test_sequencer_if #(.ERR_CNT_W(2)) if2 ();

  aoi21_test_sequencer #(.SETTLE_CYCLES(4), .LOOPS(1), .ERR_CNT_W(8)) dut0 (
    .CLK(CLK), .RST(RST), .bus(if0)
  );
  aoi21_test_sequencer #(.SETTLE_CYCLES(4), .LOOPS(2), .ERR_CNT_W(8)) dut1 (
    .CLK(CLK), .RST(RST), .bus(if1)
  );
  aoi21_test_sequencer #(.SETTLE_CYCLES(4), .LOOPS(1), .ERR_CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .bus(if2)
  );

  // CUT models: good cell, output stuck-at-0, stuck-at-1, and a bridge that drops B.
  function automatic logic cut_y(input int mode, input logic a, input logic b, input logic c);
    case (mode)
      M_SA0:    return 1'b0;
      M_SA1:    return 1'b1;
      M_BRIDGE: return ~(a | c);
      default:  return ~((a & b) | c);
    endcase
  endfunction

  assign if0.Y = cut_y(mode0, if0.A, if0.B, if0.C);
  assign if1.Y = cut_y(mode1, if1.A, if1.B, if1.C);
  assign if2.Y = cut_y(mode2, if2.A, if2.B, if2.C);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle START pulse on dut0; returns at the first BUSY cycle.
  task automatic kick0();
    if0.START = 1'b1;
    step();
    if0.START = 1'b0;
  endtask

  // Walk dut0 through its busy window, checking the drive vector every cycle.
  // Returns at the first non-busy cycle (the FINISH cycle for a normal run).
  task automatic body0(input bit hold_start, output int nbusy, output int nbad);
    logic [2:0] exp_vec;
    nbusy = 0;
    nbad  = 0;
    while (if0.BUSY === 1'b1 && nbusy < 200) begin
      exp_vec = 3'((nbusy / 5) % 8);
      if ({if0.A, if0.B, if0.C} !== exp_vec) nbad++;
      if (hold_start) if0.START = 1'b1;
      step();
      nbusy++;
    end
    if0.START = 1'b0;
  endtask

  initial begin
    int nb, nbad, nb1, nb2, nd1, nd2, nd0, guard;
    n_cmp = 0;
    n_err = 0;
    mode0 = M_GOLD;
    mode1 = M_SA0;
    mode2 = M_SA1;
    RST = 1'b1;
    if0.START = 1'b0; if0.ABORT = 1'b0;
    if1.START = 1'b0; if1.ABORT = 1'b0;
    if2.START = 1'b0; if2.ABORT = 1'b0;
    step();
    step();
    RST = 1'b0;
    step();

    // Reset state
    chk("rst_abc",   {29'd0, if0.A, if0.B, if0.C}, 32'd0);
    chk("rst_busy",  {31'd0, if0.BUSY}, 32'd0);
    chk("rst_done",  {31'd0, if0.DONE}, 32'd0);
    chk("rst_pass",  {31'd0, if0.PASS}, 32'd0);
    chk("rst_err",   {24'd0, if0.ERR_CNT}, 32'd0);
    chk("rst_fail",  {28'd0, if0.FAIL_VALID, if0.FAIL_VEC}, 32'd0);
    chk("rst_err2",  {30'd0, if2.ERR_CNT}, 32'd0);

    // Stuck-at-0: mismatches at 000, 010, 100
    mode0 = M_SA0;
    kick0();
    body0(1'b0, nb, nbad);
    chk("sa0_busy",  nb, 32'd40);
    chk("sa0_vecs",  nbad, 32'd0);
    chk("sa0_done",  {31'd0, if0.DONE}, 32'd1);
    chk("sa0_err",   {24'd0, if0.ERR_CNT}, 32'd3);
    chk("sa0_fvec",  {28'd0, if0.FAIL_VALID, if0.FAIL_VEC}, 32'h8);
    chk("sa0_pass",  {31'd0, if0.PASS}, 32'd0);
    step();
    chk("sa0_done_lo", {31'd0, if0.DONE}, 32'd0);

    // Golden run started the cycle after DONE, START held high throughout
    mode0 = M_GOLD;
    kick0();
    chk("gold_busy0", {31'd0, if0.BUSY}, 32'd1);
    chk("gold_clr",   {24'd0, if0.ERR_CNT}, 32'd0);
    chk("gold_fclr",  {31'd0, if0.FAIL_VALID}, 32'd0);
    body0(1'b1, nb, nbad);
    chk("gold_busy",  nb, 32'd39 + 32'd1);
    chk("gold_vecs",  nbad, 32'd0);
    chk("gold_done",  {31'd0, if0.DONE}, 32'd1);
    chk("gold_pass",  {31'd0, if0.PASS}, 32'd1);
    chk("gold_err",   {24'd0, if0.ERR_CNT}, 32'd0);
    chk("gold_fval",  {31'd0, if0.FAIL_VALID}, 32'd0);
    chk("gold_abc",   {29'd0, if0.A, if0.B, if0.C}, 32'd0);
    step();
    chk("gold_after", {30'd0, if0.DONE, if0.BUSY}, 32'd0);
    chk("gold_hold",  {31'd0, if0.PASS}, 32'd1);

    // Bridged CUT: only 100 fails
    mode0 = M_BRIDGE;
    kick0();
    chk("br_passclr", {31'd0, if0.PASS}, 32'd0);
    body0(1'b0, nb, nbad);
    chk("br_busy",  nb, 32'd40);
    chk("br_done",  {31'd0, if0.DONE}, 32'd1);
    chk("br_err",   {24'd0, if0.ERR_CNT}, 32'd1);
    chk("br_fvec",  {28'd0, if0.FAIL_VALID, if0.FAIL_VEC}, 32'hC);
    chk("br_pass",  {31'd0, if0.PASS}, 32'd0);
    step();

    // LOOPS=2 stuck-at-0 and 2-bit counter stuck-at-1, in parallel
    if1.START = 1'b1;
    if2.START = 1'b1;
    step();
    if1.START = 1'b0;
    if2.START = 1'b0;
    nb1 = 0; nb2 = 0; nd1 = 0; nd2 = 0;
    for (int i = 0; i < 100; i++) begin
      if (if1.BUSY === 1'b1) nb1++;
      if (if2.BUSY === 1'b1) nb2++;
      if (if1.DONE === 1'b1) nd1++;
      if (if2.DONE === 1'b1) nd2++;
      step();
    end
    chk("l2_busy",  nb1, 32'd80);
    chk("l2_done",  nd1, 32'd1);
    chk("l2_err",   {24'd0, if1.ERR_CNT}, 32'd6);
    chk("l2_fvec",  {28'd0, if1.FAIL_VALID, if1.FAIL_VEC}, 32'h8);
    chk("l2_pass",  {31'd0, if1.PASS}, 32'd0);
    chk("sat_busy", nb2, 32'd40);
    chk("sat_done", nd2, 32'd1);
    chk("sat_err",  {30'd0, if2.ERR_CNT}, 32'd3);
    chk("sat_fvec", {28'd0, if2.FAIL_VALID, if2.FAIL_VEC}, 32'h9);
    chk("sat_pass", {31'd0, if2.PASS}, 32'd0);

    // ABORT while vector 3 is settling (after mismatches at 000 and 010)
    mode0 = M_SA0;
    kick0();
    guard = 0;
    while ({if0.A, if0.B, if0.C} !== 3'b011 && guard < 60) begin
      step();
      guard++;
    end
    chk("ab_reach", {31'd0, (guard < 60)}, 32'd1);
    step();
    if0.ABORT = 1'b1;
    step();
    if0.ABORT = 1'b0;
    chk("ab_busy", {31'd0, if0.BUSY}, 32'd0);
    chk("ab_abc",  {29'd0, if0.A, if0.B, if0.C}, 32'd0);
    chk("ab_pass", {31'd0, if0.PASS}, 32'd0);
    chk("ab_err",  {24'd0, if0.ERR_CNT}, 32'd2);
    chk("ab_fvec", {28'd0, if0.FAIL_VALID, if0.FAIL_VEC}, 32'h8);
    nd0 = 0;
    for (int i = 0; i < 45; i++) begin
      if (if0.DONE === 1'b1) nd0++;
      step();
    end
    chk("ab_nodone", nd0, 32'd0);

    // ABORT in IDLE together with START: START wins
    if0.ABORT = 1'b1;
    if0.START = 1'b1;
    step();
    if0.ABORT = 1'b0;
    if0.START = 1'b0;
    chk("st_wins", {31'd0, if0.BUSY}, 32'd1);

    // Synchronous reset mid-run
    for (int i = 0; i < 12; i++) step();
    chk("pre_rst_err", {24'd0, if0.ERR_CNT}, 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_rst_busy", {30'd0, if0.BUSY, if0.DONE}, 32'd0);
    chk("mid_rst_abc",  {29'd0, if0.A, if0.B, if0.C}, 32'd0);
    chk("mid_rst_err",  {24'd0, if0.ERR_CNT}, 32'd0);
    chk("mid_rst_fail", {27'd0, if0.PASS, if0.FAIL_VALID, if0.FAIL_VEC}, 32'd0);

    // Clean run after reset
    mode0 = M_GOLD;
    kick0();
    body0(1'b0, nb, nbad);
    chk("post_busy", nb, 32'd40);
    chk("post_vecs", nbad, 32'd0);
    chk("post_done", {31'd0, if0.DONE}, 32'd1);
    chk("post_pass", {31'd0, if0.PASS}, 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aoi21_test_sequencer.md
Name: aoi21_test_sequencer

Overview:
- Built-in self-test controller for an AOI21 cell-under-test (CUT), where the CUT computes Y = ~((A & B) | C).
- Sequences all 8 input vectors into the CUT for a programmable number of sweeps and holds each vector for a settle window.
- Samples the CUT output, compares it against the golden AOI21 function, counts mismatches and records the first failing vector.
- Sits beside the standard-cell characterization/test harness; one instance drives one CUT.

Parameters:
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 1..255.
- LOOPS, 1, number of full 8-vector sweeps per run; legal range 1..255.
- ERR_CNT_W, 8, width of the saturating mismatch counter.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  reset, synchronous, active-high
- START  input  1  begin a run; honoured only in IDLE
- ABORT  input  1  terminate the run in progress
- Y  input  1  CUT output; combinational from A/B/C
- A  output  1  CUT input A, registered
- B  output  1  CUT input B, registered
- C  output  1  CUT input C, registered
- BUSY  output  1  high while a run is in progress
- DONE  output  1  one-cycle pulse when a run completes normally
- PASS  output  1  high after a completed run with ERR_CNT==0; held until the next START
- ERR_CNT  output  ERR_CNT_W  mismatch count, saturating
- FAIL_VALID  output  1  at least one mismatch has occurred in this run
- FAIL_VEC  output  3  first failing vector {A,B,C}

Behaviour:
- Reset (RST high at a clock edge):
  - State goes to IDLE.
  - A, B, C, BUSY, DONE, PASS, FAIL_VALID = 0; ERR_CNT = 0; FAIL_VEC = 3'b000.
  - Reset mid-run has the same effect; no DONE pulse.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - START=1 at an edge: next cycle state=SETTLE, BUSY=1, vector counter=0, {A,B,C}=3'b000, settle counter=SETTLE_CYCLES-1, loop counter=0.
  - The same edge clears ERR_CNT, FAIL_VALID, FAIL_VEC and PASS.
- SETTLE: vector held constant; settle counter decrements each cycle; at 0, next state=SAMPLE. Duration is exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - Y compared to exp = ~((A & B) | C) from the currently driven A/B/C.
  - On mismatch: ERR_CNT increments, saturating at 2^ERR_CNT_W-1.
  - If FAIL_VALID==0, the same edge sets FAIL_VALID=1 and FAIL_VEC={A,B,C}; later mismatches do not update FAIL_VEC.
  - If vector<7: vector+1 driven next cycle, settle counter reloaded, next state=SETTLE.
  - If vector==7 and loop<LOOPS-1: vector wraps to 0, loop+1, next state=SETTLE.
  - Else: next state=FINISH.
- Vector encoding: A=vec[2], B=vec[1], C=vec[0]; ascending order 0..7.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - BUSY is high for exactly LOOPS*8*(SETTLE_CYCLES+1) cycles.
- FINISH (one cycle): DONE=1, BUSY=0, PASS=(ERR_CNT==0), A/B/C=0, next state=IDLE. DONE is low in every other cycle.
- START while BUSY: ignored.
- ABORT:
  - ABORT=1 at any edge while BUSY: next cycle IDLE, BUSY=0, A/B/C=0, PASS=0, no DONE pulse; ERR_CNT, FAIL_* retain their values.
  - ABORT in IDLE: no effect.
  - START and ABORT together in IDLE: START wins.
- Priority: RST > ABORT > START.
- Illegal parameters (SETTLE_CYCLES=0 or LOOPS=0) are rejected by an elaboration-time check.

Test Plan:
- Golden CUT, SETTLE_CYCLES=4, LOOPS=1, START pulse: BUSY high 40 cycles, vectors 000..111 each held 5 cycles, DONE one cycle after BUSY falls, PASS=1, ERR_CNT=0, FAIL_VALID=0.
- Y stuck-at-0: ERR_CNT=3 (vectors 000, 010, 100), FAIL_VEC=3'b000, PASS=0; with LOOPS=2: ERR_CNT=6.
- Y stuck-at-1, ERR_CNT_W=2: raw count 5 saturates, ERR_CNT=3, FAIL_VEC=3'b001, PASS=0.
- Bridged CUT Y=~(A|C): ERR_CNT=1, FAIL_VEC=3'b100, FAIL_VALID=1.
- Interrupt cases: ABORT during vector 3 gives BUSY=0 next cycle, no DONE, A/B/C=0; a separate run with RST asserted mid-run gives all outputs at reset values next cycle; a following START gives a full clean 40-cycle run.
- START re-asserted every cycle while BUSY: run length unchanged at 40 cycles; START on the cycle after DONE begins a new run and clears PASS/ERR_CNT.
